frac_lutk_arith_cfg_tile: RTL and testbench

FRAC_LUTK_ARITH_CFG_TILE -- requirements
Module: frac_lutk_arith_cfg_tile

---
 rtl/frac_lutk_arith_cfg_tile_if.sv | 25 ++
 rtl/frac_lutk_arith_cfg_tile.sv | 96 +++++++++
 tb/tb_frac_lutk_arith_cfg_tile.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_lutk_arith_cfg_tile_if.sv
// Pin bundle for the fractured LUT tile: serial configuration chain, LUT datapath and load status.
interface frac_lutk_arith_cfg_tile_if #(
   parameter int LUT_K = 4
);
   logic             config_enable;
   logic             ccff_head;
   logic             ccff_tail;
   logic [LUT_K-1:0] frac_lut_in;
   logic             frac_lut_cin;
   logic [1:0]       frac_lut_half_out;
   logic             frac_lut_out;
   logic             frac_lut_cout;
   logic             cfg_valid;
   logic             cfg_error;

   modport master (
      output config_enable, ccff_head, frac_lut_in, frac_lut_cin,
      input  ccff_tail, frac_lut_half_out, frac_lut_out, frac_lut_cout, cfg_valid, cfg_error
   );

   modport slave (
      input  config_enable, ccff_head, frac_lut_in, frac_lut_cin,
      output ccff_tail, frac_lut_half_out, frac_lut_out, frac_lut_cout, cfg_valid, cfg_error
   );
endinterface

// File: rtl/frac_lutk_arith_cfg_tile.sv
// Fracturable K-LUT with arithmetic mode, loaded through a parity-checked shadow scan chain
// that only commits to the live configuration after a complete, even-parity load.
module frac_lutk_arith_cfg_tile #(
   parameter int LUT_K = 4
) (
   input logic                       prog_clk,
   input logic                       pReset,
   frac_lutk_arith_cfg_tile_if.slave bus
);
   localparam int TT_BITS   = 1 << LUT_K;
   localparam int CHAIN_LEN = TT_BITS + 3;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } state_t;

   state_t               state;
   logic [CHAIN_LEN-1:0] shadow;
   logic [CHAIN_LEN-2:0] active;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 cfg_valid_q;
   logic                 cfg_error_q;

   // The shadow chain is shifted freely; the live configuration only changes on a clean check.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state       <= IDLE;
         shadow      <= '0;
         active      <= '0;
         bit_cnt     <= '0;
         cfg_valid_q <= 1'b0;
         cfg_error_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.config_enable) begin
                  shadow      <= {shadow[CHAIN_LEN-2:0], bus.ccff_head};
                  bit_cnt     <= CNT_W'(1);
                  cfg_valid_q <= 1'b0;
                  cfg_error_q <= 1'b0;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               if (bus.config_enable) begin
                  shadow <= {shadow[CHAIN_LEN-2:0], bus.ccff_head};
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               state <= IDLE;
               if ((bit_cnt == CNT_FULL) && !(^shadow)) begin
                  active      <= shadow[CHAIN_LEN-2:0];
                  cfg_valid_q <= 1'b1;
               end else begin
                  cfg_error_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [TT_BITS-1:0] truth;
   logic [1:0]         mode;
   logic [LUT_K-2:0]   idx;
   logic               half0;
   logic               half1;
   logic               arith;

   assign truth = active[TT_BITS-1:0];
   assign mode  = active[TT_BITS+1:TT_BITS];
   assign idx   = bus.frac_lut_in[LUT_K-2:0];
   assign half0 = truth[{1'b0, idx}];
   assign half1 = truth[{1'b1, idx}];
   assign arith = (mode == 2'b10);

   // In arith mode the lower half is the propagate term and the upper half the generate term.
   assign bus.frac_lut_half_out = {half1, half0};
   assign bus.frac_lut_out      = arith ? (half0 ^ bus.frac_lut_cin)
                                        : (bus.frac_lut_in[LUT_K-1] ? half1 : half0);
   assign bus.frac_lut_cout     = arith ? (half0 ? bus.frac_lut_cin : half1) : 1'b0;

   assign bus.ccff_tail = shadow[CHAIN_LEN-1];
   assign bus.cfg_valid = cfg_valid_q;
   assign bus.cfg_error = cfg_error_q;
endmodule

// File: tb/tb_frac_lutk_arith_cfg_tile.sv
// Self-checking bench for frac_lutk_arith_cfg_tile: fixed vector tables for known loads plus
// random loads and inputs compared against a behavioural model of the chain and the LUT.
module tb_frac_lutk_arith_cfg_tile;
   localparam int LUT_K     = 4;
   localparam int TT        = 1 << LUT_K;
   localparam int HALF      = TT / 2;
   localparam int CHAIN_LEN = TT + 3;

   typedef struct {
      string            name;
      logic [LUT_K-1:0] lut_in;
      logic             cin;
      logic             exp_out;
      logic [1:0]       exp_half;
      logic             exp_cout;
   } vec_t;

   logic prog_clk;
   logic pReset;
   int   checks;
   int   failures;

   logic [TT-1:0] m_table;
   logic [1:0]    m_mode;
   logic          m_valid;
   logic          m_error;
   bit            hist[$];

   vec_t and4_vecs[4];
   vec_t arith_vecs[5];

   frac_lutk_arith_cfg_tile_if #(.LUT_K(LUT_K)) bus ();

   frac_lutk_arith_cfg_tile #(.LUT_K(LUT_K)) dut (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .bus      (bus.slave)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [LUT_K-1:0] lut_in, input logic cin);
      @(negedge prog_clk);
      bus.frac_lut_in  = lut_in;
      bus.frac_lut_cin = cin;
      #1;
   endtask

   function automatic logic [CHAIN_LEN-1:0] make_image(input logic [TT-1:0] tbl, input logic [1:0] mode);
      return {^{mode, tbl}, mode, tbl};
   endfunction

   // The bit shifted in CHAIN_LEN-1 shifts ago sits at the end of the chain.
   function automatic bit expected_tail();
      if (hist.size() >= CHAIN_LEN) return hist[hist.size() - CHAIN_LEN];
      return 1'b0;
   endfunction

   function automatic void model_eval(input int lut_in, input bit cin,
                                      output bit out, output bit [1:0] half, output bit cout);
      int low;
      bit p;
      bit g;
      low  = lut_in % HALF;
      p    = m_table[low];
      g    = m_table[HALF + low];
      half = {g, p};
      if (m_mode == 2'b10) begin
         out  = p ^ cin;
         cout = p ? cin : g;
      end else begin
         out  = (lut_in >= HALF) ? g : p;
         cout = 1'b0;
      end
   endfunction

   task automatic check_zero_outputs(input string tag);
      checkOutput({tag, " out"},   8'(bus.frac_lut_out),      8'd0);
      checkOutput({tag, " half"},  8'(bus.frac_lut_half_out), 8'd0);
      checkOutput({tag, " cout"},  8'(bus.frac_lut_cout),     8'd0);
      checkOutput({tag, " tail"},  8'(bus.ccff_tail),         8'd0);
      checkOutput({tag, " valid"}, 8'(bus.cfg_valid),         8'd0);
      checkOutput({tag, " error"}, 8'(bus.cfg_error),         8'd0);
   endtask

   task automatic model_clear();
      hist.delete();
      m_table = '0;
      m_mode  = 2'b00;
      m_valid = 1'b0;
      m_error = 1'b0;
   endtask

   task automatic reset_dut();
      logic [31:0] r;
      @(negedge prog_clk);
      pReset = 1'b1;
      model_clear();
      for (int k = 0; k < 3; k++) begin
         r = $urandom;
         bus.config_enable = r[0];
         bus.ccff_head     = r[1];
         bus.frac_lut_in   = r[LUT_K+1:2];
         bus.frac_lut_cin  = r[LUT_K+2];
         #1;
         check_zero_outputs("reset");
         @(negedge prog_clk);
      end
      bus.config_enable = 1'b0;
      bus.ccff_head     = 1'b0;
      pReset            = 1'b0;
   endtask

   // Shifts bits[n-1] first, then ends the load and checks the commit decision.
   task automatic shift_bits(input logic [63:0] bits, input int n, input string tag);
      logic [CHAIN_LEN-1:0] sh;
      m_valid = 1'b0;
      m_error = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge prog_clk);
         bus.config_enable = 1'b1;
         bus.ccff_head     = bits[i];
         @(posedge prog_clk);
         hist.push_back(bits[i]);
         #2;
         checkOutput({tag, " tail"}, 8'(bus.ccff_tail), 8'(expected_tail()));
         if (i == n - 1) begin
            checkOutput({tag, " valid cleared"}, 8'(bus.cfg_valid), 8'(m_valid));
            checkOutput({tag, " error cleared"}, 8'(bus.cfg_error), 8'(m_error));
         end
      end
      @(negedge prog_clk);
      bus.config_enable = 1'b0;
      bus.ccff_head     = 1'b0;
      @(posedge prog_clk);
      #2;
      checkOutput({tag, " valid in check"}, 8'(bus.cfg_valid), 8'd0);
      @(posedge prog_clk);
      #2;
      for (int k = 0; k < CHAIN_LEN; k++) begin
         sh[k] = (hist.size() > k) ? hist[hist.size() - 1 - k] : 1'b0;
      end
      if (n == CHAIN_LEN && (^sh) == 1'b0) begin
         m_table = sh[TT-1:0];
         m_mode  = sh[TT+1:TT];
         m_valid = 1'b1;
      end else begin
         m_error = 1'b1;
      end
      checkOutput({tag, " cfg_valid"}, 8'(bus.cfg_valid), 8'(m_valid));
      checkOutput({tag, " cfg_error"}, 8'(bus.cfg_error), 8'(m_error));
   endtask

   task automatic run_vector(input vec_t v);
      applyStimulus(v.lut_in, v.cin);
      checkOutput({v.name, " out"},  8'(bus.frac_lut_out),      8'(v.exp_out));
      checkOutput({v.name, " half"}, 8'(bus.frac_lut_half_out), 8'(v.exp_half));
      checkOutput({v.name, " cout"}, 8'(bus.frac_lut_cout),     8'(v.exp_cout));
   endtask

   task automatic check_random_inputs(input string tag, input int n);
      logic [31:0] r;
      bit          e_out;
      bit          e_cout;
      bit [1:0]    e_half;
      for (int k = 0; k < n; k++) begin
         r = $urandom;
         applyStimulus(r[LUT_K-1:0], r[LUT_K]);
         model_eval(int'(r[LUT_K-1:0]), r[LUT_K], e_out, e_half, e_cout);
         checkOutput({tag, " out"},  8'(bus.frac_lut_out),      8'(e_out));
         checkOutput({tag, " half"}, 8'(bus.frac_lut_half_out), 8'(e_half));
         checkOutput({tag, " cout"}, 8'(bus.frac_lut_cout),     8'(e_cout));
      end
   endtask

   initial begin
      logic [TT-1:0]        and4_tbl;
      logic [TT-1:0]        arith_tbl;
      logic [TT-1:0]        rnd_tbl;
      logic [1:0]           rnd_mode;
      logic [CHAIN_LEN-1:0] img;
      logic [63:0]          pass_bits;
      logic [31:0]          r;

      checks   = 0;
      failures = 0;
      pReset   = 1'b1;
      bus.config_enable = 1'b0;
      bus.ccff_head     = 1'b0;
      bus.frac_lut_in   = '0;
      bus.frac_lut_cin  = 1'b0;

      and4_tbl = '0;
      and4_tbl[TT-1] = 1'b1;
      for (int i = 0; i < HALF; i++) begin
         arith_tbl[i]        = 1'((i % 2) ^ ((i / 2) % 2));
         arith_tbl[HALF + i] = 1'((i % 2) & ((i / 2) % 2));
      end

      and4_vecs[0]  = '{"and4 1111", 4'b1111, 1'b0, 1'b1, 2'b10, 1'b0};
      and4_vecs[1]  = '{"and4 0111", 4'b0111, 1'b1, 1'b0, 2'b10, 1'b0};
      and4_vecs[2]  = '{"and4 0000", 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
      and4_vecs[3]  = '{"and4 1110", 4'b1110, 1'b1, 1'b0, 2'b00, 1'b0};
      arith_vecs[0] = '{"arith 0001 c1", 4'b0001, 1'b1, 1'b0, 2'b01, 1'b1};
      arith_vecs[1] = '{"arith 0011 c0", 4'b0011, 1'b0, 1'b0, 2'b10, 1'b1};
      arith_vecs[2] = '{"arith 0000 c1", 4'b0000, 1'b1, 1'b1, 2'b00, 1'b0};
      arith_vecs[3] = '{"arith 0010 c0", 4'b0010, 1'b0, 1'b1, 2'b01, 1'b0};
      arith_vecs[4] = '{"arith 1111 c1", 4'b1111, 1'b1, 1'b1, 2'b10, 1'b1};

      reset_dut();

      shift_bits(64'(make_image(and4_tbl, 2'b00)), CHAIN_LEN, "and4 load");
      foreach (and4_vecs[i]) run_vector(and4_vecs[i]);

      shift_bits(64'(make_image(arith_tbl, 2'b10)), CHAIN_LEN, "arith load");
      foreach (arith_vecs[i]) run_vector(arith_vecs[i]);

      for (int n = 0; n < 6; n++) begin
         r        = $urandom;
         rnd_tbl  = r[TT-1:0];
         rnd_mode = 2'(n % 4);
         shift_bits(64'(make_image(rnd_tbl, rnd_mode)), CHAIN_LEN, "random load");
         check_random_inputs("random cfg", 8);
      end

      shift_bits(64'(make_image(and4_tbl, 2'b00)), CHAIN_LEN, "and4 reload");
      shift_bits(64'(make_image(arith_tbl, 2'b10)) >> 1, CHAIN_LEN - 1, "short load");
      foreach (and4_vecs[i]) run_vector(and4_vecs[i]);

      img = make_image(arith_tbl, 2'b10);
      img[CHAIN_LEN-1] = ~img[CHAIN_LEN-1];
      shift_bits(64'(img), CHAIN_LEN, "parity fault");
      foreach (and4_vecs[i]) run_vector(and4_vecs[i]);

      reset_dut();
      pass_bits = {$urandom, $urandom};
      shift_bits(pass_bits, 2 * CHAIN_LEN, "pass-through");
      check_random_inputs("after pass-through", 4);

      shift_bits(64'(make_image(and4_tbl, 2'b00)), CHAIN_LEN, "pre-abort load");
      img = make_image(and4_tbl, 2'b00);
      for (int i = CHAIN_LEN - 1; i > CHAIN_LEN - 11; i--) begin
         @(negedge prog_clk);
         bus.config_enable = 1'b1;
         bus.ccff_head     = img[i];
         @(posedge prog_clk);
      end
      @(negedge prog_clk);
      bus.frac_lut_in = '1;
      pReset          = 1'b1;
      #1;
      model_clear();
      check_zero_outputs("abort in reset");
      bus.config_enable = 1'b0;
      @(negedge prog_clk);
      pReset = 1'b0;
      repeat (3) @(posedge prog_clk);
      #2;
      check_zero_outputs("after abort");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
